// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand sequencer.
package calc_pkg;

   localparam int unsigned CALC_DATA_W = 16;
   localparam int unsigned FLAGS_W     = 5;
   localparam int unsigned STATE_W     = 3;

   // Bit positions inside calc_flags / result_flags
   localparam int unsigned FLG_UNDERFLOW = 0;
   localparam int unsigned FLG_OVERFLOW  = 1;
   localparam int unsigned FLG_INEXACT   = 2;
   localparam int unsigned FLG_EXCEPTION = 3;
   localparam int unsigned FLG_INVALID   = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_GET_A = 3'd0,
      ST_GET_B = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SHOW  = 3'd4
   } state_e;

   // Latched status that accompanies a result
   typedef struct packed {
      logic               sign;
      logic [FLAGS_W-1:0] flags;
   } calc_status_t;

endpackage

// File: rtl/calc_operand_sequencer_if.sv
// Handshake between the operand sequencer (master) and the calculator core (slave).
interface calc_operand_sequencer_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              calc_start;
   logic              calc_ready;
   logic [DATA_W-1:0] calc_sum;
   logic              calc_sign;
   logic [4:0]        calc_flags;

   modport master (
      output op_a, op_b, calc_start,
      input  calc_ready, calc_sum, calc_sign, calc_flags
   );

   modport slave (
      input  op_a, op_b, calc_start,
      output calc_ready, calc_sum, calc_sign, calc_flags
   );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level counter, one-cycle press on 0->1.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive cycles the synchronized level differs from the accepted one
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = sync2_q;
         press_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Synchronizer and debounce state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;
endmodule

// File: rtl/calc_operand_sequencer.sv
// Initiator for the calculator core: capture two operands, start, await ready or timeout, show.
module calc_operand_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned DATA_W          = CALC_DATA_W,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        btn_enter,
   input  logic                        btn_clear,
   input  logic [DATA_W-1:0]           switches,
   calc_operand_sequencer_if.master    core,
   output logic [DATA_W-1:0]           result,
   output logic                        result_sign,
   output logic [FLAGS_W-1:0]          result_flags,
   output logic                        result_valid,
   output logic                        timeout,
   output logic [STATE_W-1:0]          state_o
);
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic enter_press, clear_press;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic              start_q, start_d;
   logic [DATA_W-1:0] result_q, result_d;
   calc_status_t      status_q, status_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;
   logic              arm_q, arm_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [TMO_W-1:0]  tmo_inc;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .clk(clk), .rst(rst), .btn_raw(btn_enter), .press(enter_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk(clk), .rst(rst), .btn_raw(btn_clear), .press(clear_press)
   );

   // Next-state and register updates; clear overrides everything including enter
   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      result_d  = result_q;
      status_d  = status_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      arm_d     = arm_q;
      tmo_cnt_d = tmo_cnt_q;
      tmo_inc   = tmo_cnt_q + TMO_W'(1);
      start_d   = 1'b0;

      if (clear_press) begin
         op_a_d    = '0;
         op_b_d    = '0;
         valid_d   = 1'b0;
         timeout_d = 1'b0;
         state_d   = ST_GET_A;
      end else begin
         unique case (state_q)
            ST_GET_A: if (enter_press) begin
               op_a_d    = switches;
               valid_d   = 1'b0;
               timeout_d = 1'b0;
               state_d   = ST_GET_B;
            end
            ST_GET_B: if (enter_press) begin
               op_b_d  = switches;
               state_d = ST_START;
            end
            ST_START: begin
               arm_d     = 1'b0;
               tmo_cnt_d = '0;
               state_d   = ST_WAIT;
            end
            ST_WAIT: begin
               // A ready is only trusted after it has been seen low once in this op
               arm_d = arm_q | ~core.calc_ready;
               if (arm_q && core.calc_ready) begin
                  result_d = core.calc_sum;
                  status_d = '{sign: core.calc_sign, flags: core.calc_flags};
                  valid_d  = 1'b1;
                  state_d  = ST_SHOW;
               end else if (tmo_inc == TMO_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = ST_SHOW;
               end else begin
                  tmo_cnt_d = tmo_inc;
               end
            end
            ST_SHOW: if (enter_press) state_d = ST_GET_A;
            default: state_d = ST_GET_A;
         endcase
      end

      start_d = (state_d == ST_START);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_GET_A;
         op_a_q    <= '0;
         op_b_q    <= '0;
         start_q   <= 1'b0;
         result_q  <= '0;
         status_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         arm_q     <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         start_q   <= start_d;
         result_q  <= result_d;
         status_q  <= status_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         arm_q     <= arm_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign core.op_a       = op_a_q;
   assign core.op_b       = op_b_q;
   assign core.calc_start = start_q;
   assign result          = result_q;
   assign result_sign     = status_q.sign;
   assign result_flags    = status_q.flags;
   assign result_valid    = valid_q;
   assign timeout         = timeout_q;
   assign state_o         = state_q;
endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: per-cycle reference model plus directed literal checks.
module tb_calc_operand_sequencer;
   localparam int DB = 4;
   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        btn_enter, btn_clear;
   logic [15:0] switches;
   logic [15:0] result;
   logic        result_sign;
   logic [4:0]  result_flags;
   logic        result_valid;
   logic        timeout;
   logic [2:0]  state_o;

   calc_operand_sequencer_if #(.DATA_W(16)) core_if ();

   calc_operand_sequencer #(
      .DATA_W(16), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_clear(btn_clear),
      .switches(switches), .core(core_if), .result(result),
      .result_sign(result_sign), .result_flags(result_flags),
      .result_valid(result_valid), .timeout(timeout), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- core responder ----------------
   int        core_mode = 0;      // 0: ready after core_dly, 1: never, 2: stale-high then re-raise
   int        core_dly  = 3;
   bit        core_force_high = 0;
   logic      core_sign  = 1'b0;
   logic [4:0] core_flags = 5'b0;
   int        start_cnt = 0;
   int        dly = 0, drop = 0;

   initial begin
      core_if.calc_ready = 1'b0;
      core_if.calc_sum   = '0;
      core_if.calc_sign  = 1'b0;
      core_if.calc_flags = '0;
   end

   always @(negedge clk) begin
      if (core_if.calc_start === 1'b1) begin
         start_cnt++;
         case (core_mode)
            0: begin core_if.calc_ready = 1'b0; dly = core_dly; end
            1: begin core_if.calc_ready = 1'b0; dly = 0; end
            default: drop = 3;
         endcase
      end else if (drop > 0) begin
         drop--;
         if (drop == 0) begin core_if.calc_ready = 1'b0; dly = 2; end
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) begin
            core_if.calc_ready = 1'b1;
            core_if.calc_sum   = core_if.op_a + core_if.op_b;
            core_if.calc_sign  = core_sign;
            core_if.calc_flags = core_flags;
         end
      end else if (core_force_high) begin
         core_if.calc_ready = 1'b1;
      end
   end

   // ---------------- reference model ----------------
   // A button level is accepted once the last DB synchronized samples all show the new level.
   bit m_s1[2], m_s2[2], m_lvl[2], m_press[2];
   bit h_en[$], h_cl[$];
   int          m_st;
   logic [15:0] m_opa, m_opb, m_res;
   logic        m_sign, m_rv, m_to;
   logic [4:0]  m_flags;
   bit          m_seen_low;
   int          m_wait;

   function automatic bit settled(input bit q[$], input bit v);
      if (q.size() < DB) return 1'b0;
      foreach (q[i]) if (q[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s1 = '{0, 0}; m_s2 = '{0, 0}; m_lvl = '{0, 0}; m_press = '{0, 0};
         h_en.delete(); h_cl.delete();
         m_st = 0; m_opa = 0; m_opb = 0; m_res = 0; m_sign = 0; m_flags = 0;
         m_rv = 0; m_to = 0; m_seen_low = 0; m_wait = 0;
      end else begin
         if (m_press[1]) begin
            m_opa = 0; m_opb = 0; m_rv = 0; m_to = 0; m_st = 0;
         end else begin
            case (m_st)
               0: if (m_press[0]) begin m_opa = switches; m_rv = 0; m_to = 0; m_st = 1; end
               1: if (m_press[0]) begin m_opb = switches; m_st = 2; end
               2: begin m_seen_low = 0; m_wait = 0; m_st = 3; end
               3: begin
                  if (m_seen_low && core_if.calc_ready) begin
                     m_res = core_if.calc_sum; m_sign = core_if.calc_sign;
                     m_flags = core_if.calc_flags; m_rv = 1; m_st = 4;
                  end else begin
                     m_wait++;
                     if (m_wait == TO - 1) begin m_to = 1; m_st = 4; end
                  end
                  if (!core_if.calc_ready) m_seen_low = 1;
               end
               default: if (m_press[0]) m_st = 0;
            endcase
         end
         h_en.push_back(m_s2[0]);
         if (h_en.size() > DB) void'(h_en.pop_front());
         m_press[0] = 0;
         if (settled(h_en, ~m_lvl[0])) begin m_lvl[0] = ~m_lvl[0]; m_press[0] = m_lvl[0]; end
         m_s2[0] = m_s1[0]; m_s1[0] = btn_enter;
         h_cl.push_back(m_s2[1]);
         if (h_cl.size() > DB) void'(h_cl.pop_front());
         m_press[1] = 0;
         if (settled(h_cl, ~m_lvl[1])) begin m_lvl[1] = ~m_lvl[1]; m_press[1] = m_lvl[1]; end
         m_s2[1] = m_s1[1]; m_s1[1] = btn_clear;
      end
   end

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      if (rst === 1'b1) begin
         check("op_a",         32'(core_if.op_a),       32'(m_opa));
         check("op_b",         32'(core_if.op_b),       32'(m_opb));
         check("calc_start",   32'(core_if.calc_start), 32'(m_st == 2));
         check("result",       32'(result),             32'(m_res));
         check("result_sign",  32'(result_sign),        32'(m_sign));
         check("result_flags", 32'(result_flags),       32'(m_flags));
         check("result_valid", 32'(result_valid),       32'(m_rv));
         check("timeout",      32'(timeout),            32'(m_to));
         check("state_o",      32'(state_o),            32'(m_st));
      end
   end

   // ---------------- stimulus ----------------
   task automatic press_enter(input logic [15:0] sw);
      switches  = sw;
      btn_enter = 1'b1;
      tick(8);
      btn_enter = 1'b0;
      tick(8);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n = 0;
      while (state_o !== s && n < budget) begin tick(1); n++; end
      check("reach_state", 32'(state_o), 32'(s));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int starts_before;
      rst = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; switches = '0;
      tick(3);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_start", 32'(core_if.calc_start), 32'd0);
      rst = 1'b1;
      tick(2);

      // 1: basic operation
      core_mode = 0; core_dly = 3;
      press_enter(16'h0012);
      press_enter(16'h0034);
      wait_state(3'd4, 40);
      check("t1_op_a", 32'(core_if.op_a), 32'h0012);
      check("t1_op_b", 32'(core_if.op_b), 32'h0034);
      check("t1_result", 32'(result), 32'h0046);
      check("t1_valid", 32'(result_valid), 32'd1);
      check("t1_starts", 32'(start_cnt), 32'd1);

      // 2: bouncy enter yields one press
      press_enter(16'h0000);
      switches = 16'h00AB;
      for (int i = 0; i < 2; i++) begin
         btn_enter = 1'b1; tick(2);
         btn_enter = 1'b0; tick(2);
      end
      btn_enter = 1'b1; tick(10);
      btn_enter = 1'b0; tick(10);
      check("t2_state", 32'(state_o), 32'd1);
      check("t2_op_a", 32'(core_if.op_a), 32'h00AB);

      // 3: stale ready must drop before a result is accepted
      core_mode = 2; core_flags = 5'b00010; core_force_high = 1;
      tick(2);
      press_enter(16'h0100);
      wait_state(3'd4, 40);
      check("t3_result", 32'(result), 32'h01AB);
      check("t3_flags", 32'(result_flags), 32'h02);
      check("t3_valid", 32'(result_valid), 32'd1);
      core_force_high = 0; core_mode = 1; core_flags = 5'b0;

      // 4: no ready -> timeout
      press_enter(16'h0000);
      press_enter(16'h1111);
      switches = 16'h2222; btn_enter = 1'b1;
      k = 0;
      while (core_if.calc_start !== 1'b1 && k < 30) begin tick(1); k++; end
      check("t4_start_seen", 32'(core_if.calc_start), 32'd1);
      k = 0;
      while (timeout !== 1'b1 && k < 40) begin tick(1); k++; end
      check("t4_timeout_latency", 32'(k), 32'd16);
      check("t4_valid", 32'(result_valid), 32'd0);
      check("t4_state", 32'(state_o), 32'd4);
      btn_enter = 1'b0; tick(8);
      press_enter(16'h0000);
      check("t4_back_get_a", 32'(state_o), 32'd0);

      // 5: clear during WAIT, late ready ignored
      core_mode = 0; core_dly = 14;
      press_enter(16'h0005);
      switches = 16'h0007; btn_enter = 1'b1;
      tick(8);
      btn_enter = 1'b0; btn_clear = 1'b1;
      tick(8);
      btn_clear = 1'b0;
      tick(20);
      check("t5_state", 32'(state_o), 32'd0);
      check("t5_op_a", 32'(core_if.op_a), 32'd0);
      check("t5_op_b", 32'(core_if.op_b), 32'd0);
      check("t5_valid", 32'(result_valid), 32'd0);

      // 6: enter+clear together in GET_B
      press_enter(16'h0009);
      check("t6_get_b", 32'(state_o), 32'd1);
      starts_before = start_cnt;
      btn_enter = 1'b1; btn_clear = 1'b1;
      tick(8);
      btn_enter = 1'b0; btn_clear = 1'b0;
      tick(8);
      check("t6_state", 32'(state_o), 32'd0);
      check("t6_no_start", 32'(start_cnt), 32'(starts_before));
      check("t6_op_a", 32'(core_if.op_a), 32'd0);

      // 6b: async reset mid-WAIT
      core_mode = 1;
      press_enter(16'h0001);
      switches = 16'h0002; btn_enter = 1'b1;
      wait_state(3'd3, 20);
      #2 rst = 1'b0;
      #1;
      check("rst_async_state", 32'(state_o), 32'd0);
      check("rst_async_op_a", 32'(core_if.op_a), 32'd0);
      check("rst_async_op_b", 32'(core_if.op_b), 32'd0);
      check("rst_async_start", 32'(core_if.calc_start), 32'd0);
      check("rst_async_result", 32'(result), 32'd0);
      check("rst_async_flags", 32'({result_sign, result_flags, result_valid, timeout}), 32'd0);
      btn_enter = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(12);
      check("post_rst_state", 32'(state_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
